// File: rtl/vram_pkg.sv
// Shared constants, opcodes and engine state encoding for the text-VRAM blit arbiter.
package vram_pkg;
    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int CELLS  = COLS * ROWS;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] BLANK_CHAR = 8'h20;
    localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(CELLS - 1);
    localparam logic [4:0]        ROWS5      = 5'(ROWS);
    localparam logic [5:0]        ROWS6      = 6'(ROWS);

    localparam logic [1:0] OP_SCROLL = 2'd0;
    localparam logic [1:0] OP_CLEAR  = 2'd1;
    localparam logic [1:0] OP_FILL   = 2'd2;
    localparam logic [1:0] OP_NOP    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_PRIME, S_COPY, S_DRAIN, S_FILL, S_DONE
    } state_t;

    // First cell of a row; the product is truncated to the address width.
    function automatic logic [ADDR_W-1:0] row_base(input logic [5:0] r);
        return ADDR_W'(r) * ADDR_W'(COLS);
    endfunction
endpackage

// File: rtl/vram_blit_arbiter_if.sv
// Command, CPU-write, display-read and text-RAM signals of the blit arbiter.
interface vram_blit_arbiter_if;
    import vram_pkg::*;

    // cmd_valid/cmd_ready and cpu_w_valid/cpu_w_ready: a transfer happens on a rising
    // edge where both are high; a requester holds valid and its payload until then.
    logic              blanking_start;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [4:0]        cmd_row;
    logic [4:0]        cmd_count;
    logic [DATA_W-1:0] cmd_char;
    logic              busy;
    logic              done;
    logic              cpu_w_valid;
    logic [ADDR_W-1:0] cpu_w_addr;
    logic [DATA_W-1:0] cpu_w_data;
    logic              cpu_w_ready;
    logic              disp_r_en;
    logic [ADDR_W-1:0] disp_r_addr;
    logic              ram_r_en;
    logic [ADDR_W-1:0] ram_r_addr;
    logic [DATA_W-1:0] ram_dout;
    logic              ram_w_en;
    logic [ADDR_W-1:0] ram_w_addr;
    logic [DATA_W-1:0] ram_w_data;
    state_t            state_dbg;

    modport slave (
        input  blanking_start, cmd_valid, cmd_op, cmd_row, cmd_count, cmd_char,
               cpu_w_valid, cpu_w_addr, cpu_w_data, disp_r_en, disp_r_addr, ram_dout,
        output cmd_ready, busy, done, cpu_w_ready, ram_r_en, ram_r_addr,
               ram_w_en, ram_w_addr, ram_w_data, state_dbg
    );

    modport master (
        output blanking_start, cmd_valid, cmd_op, cmd_row, cmd_count, cmd_char,
               cpu_w_valid, cpu_w_addr, cpu_w_data, disp_r_en, disp_r_addr, ram_dout,
        input  cmd_ready, busy, done, cpu_w_ready, ram_r_en, ram_r_addr,
               ram_w_en, ram_w_addr, ram_w_data, state_dbg
    );
endinterface

// File: rtl/vram_port_mux.sv
// Combinational ownership mux for the text-RAM read and write ports.
module vram_port_mux
    import vram_pkg::*;
(
    input  logic              rst,
    input  state_t            state,
    input  logic              eng_r_en,
    input  logic [ADDR_W-1:0] eng_r_addr,
    input  logic              eng_w_en,
    input  logic [ADDR_W-1:0] eng_w_addr,
    input  logic [DATA_W-1:0] eng_w_data,
    input  logic              disp_r_en,
    input  logic [ADDR_W-1:0] disp_r_addr,
    input  logic              cpu_w_valid,
    input  logic [ADDR_W-1:0] cpu_w_addr,
    input  logic [DATA_W-1:0] cpu_w_data,
    output logic              cpu_w_ready,
    output logic              ram_r_en,
    output logic [ADDR_W-1:0] ram_r_addr,
    output logic              ram_w_en,
    output logic [ADDR_W-1:0] ram_w_addr,
    output logic [DATA_W-1:0] ram_w_data
);
    logic eng_owns_rd;
    logic eng_owns_wr;

    assign eng_owns_rd = (state == S_PRIME) || (state == S_COPY);
    assign eng_owns_wr = (state == S_COPY) || (state == S_DRAIN) || (state == S_FILL);

    always_comb begin
        cpu_w_ready = 1'b0;
        ram_r_en    = 1'b0;
        ram_r_addr  = '0;
        ram_w_en    = 1'b0;
        ram_w_addr  = '0;
        ram_w_data  = '0;
        if (!rst) begin
            if (eng_owns_rd) begin
                ram_r_en   = eng_r_en;
                ram_r_addr = eng_r_addr;
            end else if (disp_r_en && (disp_r_addr <= LAST_CELL)) begin
                ram_r_en   = 1'b1;
                ram_r_addr = disp_r_addr;
            end
            // Out-of-screen CPU writes are acknowledged but never reach the RAM.
            if (eng_owns_wr) begin
                ram_w_en   = eng_w_en;
                ram_w_addr = eng_w_addr;
                ram_w_data = eng_w_data;
            end else begin
                cpu_w_ready = cpu_w_valid;
                if (cpu_w_valid && (cpu_w_addr <= LAST_CELL)) begin
                    ram_w_en   = 1'b1;
                    ram_w_addr = cpu_w_addr;
                    ram_w_data = cpu_w_data;
                end
            end
        end
    end
endmodule

// File: rtl/vram_blit_arbiter.sv
// Command-driven scroll/clear/fill engine for the 80x30 text VRAM, sharing the RAM
// ports with the display read path and already-synchronised CPU writes.
module vram_blit_arbiter
    import vram_pkg::*;
(
    input  logic               vgaClk,
    input  logic               rst,
    vram_blit_arbiter_if.slave bus
);
    state_t            state, state_n;
    logic [1:0]        op_q, op_n;
    logic [4:0]        row_q, row_n;
    logic [4:0]        cnt_q, cnt_n;
    logic [5:0]        sum_q, sum_n;
    logic [DATA_W-1:0] fill_q, fill_n;
    logic [ADDR_W-1:0] src_q, src_n;
    logic [ADDR_W-1:0] dst_q, dst_n;
    logic [ADDR_W-1:0] lim_q, lim_n;
    logic [5:0]        sum_in;
    logic [5:0]        end_row;
    logic              eng_r_en, eng_w_en;
    logic [ADDR_W-1:0] eng_r_addr, eng_w_addr;
    logic [DATA_W-1:0] eng_w_data;

    assign sum_in  = {1'b0, bus.cmd_row} + {1'b0, bus.cmd_count};
    assign end_row = (sum_in >= ROWS6) ? ROWS6 : sum_in;

    always_ff @(posedge vgaClk) begin
        if (rst) begin
            state  <= S_IDLE;
            op_q   <= '0;
            row_q  <= '0;
            cnt_q  <= '0;
            sum_q  <= '0;
            fill_q <= '0;
            src_q  <= '0;
            dst_q  <= '0;
            lim_q  <= '0;
        end else begin
            state  <= state_n;
            op_q   <= op_n;
            row_q  <= row_n;
            cnt_q  <= cnt_n;
            sum_q  <= sum_n;
            fill_q <= fill_n;
            src_q  <= src_n;
            dst_q  <= dst_n;
            lim_q  <= lim_n;
        end
    end

    always_comb begin
        state_n    = state;
        op_n       = op_q;
        row_n      = row_q;
        cnt_n      = cnt_q;
        sum_n      = sum_q;
        fill_n     = fill_q;
        src_n      = src_q;
        dst_n      = dst_q;
        lim_n      = lim_q;
        eng_r_en   = 1'b0;
        eng_r_addr = src_q;
        eng_w_en   = 1'b0;
        eng_w_addr = dst_q;
        eng_w_data = fill_q;
        unique case (state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    op_n   = bus.cmd_op;
                    row_n  = bus.cmd_row;
                    cnt_n  = bus.cmd_count;
                    sum_n  = sum_in;
                    fill_n = (bus.cmd_op == OP_CLEAR) ? BLANK_CHAR : bus.cmd_char;
                    dst_n  = row_base({1'b0, bus.cmd_row});
                    src_n  = row_base(sum_in);
                    // A scroll always refills through the last cell of the screen.
                    lim_n  = (bus.cmd_op == OP_SCROLL) ? LAST_CELL
                                                       : row_base(end_row) - ADDR_W'(1);
                    state_n = S_ARMED;
                end
            end
            S_ARMED: begin
                if (bus.blanking_start) begin
                    if ((op_q == OP_NOP) || (cnt_q == 5'd0) || (row_q >= ROWS5))
                        state_n = S_DONE;
                    else if ((op_q == OP_SCROLL) && (sum_q < ROWS6))
                        state_n = S_PRIME;
                    else
                        state_n = S_FILL;
                end
            end
            S_PRIME: begin
                eng_r_en = 1'b1;
                src_n    = src_q + ADDR_W'(1);
                state_n  = S_COPY;
            end
            S_COPY: begin
                // Write the word read last cycle while issuing the next read.
                eng_w_en   = 1'b1;
                eng_w_data = bus.ram_dout;
                dst_n      = dst_q + ADDR_W'(1);
                eng_r_en   = 1'b1;
                src_n      = src_q + ADDR_W'(1);
                if (src_q == LAST_CELL)
                    state_n = S_DRAIN;
            end
            S_DRAIN: begin
                eng_w_en   = 1'b1;
                eng_w_data = bus.ram_dout;
                dst_n      = dst_q + ADDR_W'(1);
                state_n    = S_FILL;
            end
            S_FILL: begin
                eng_w_en = 1'b1;
                dst_n    = dst_q + ADDR_W'(1);
                if (dst_q == lim_q)
                    state_n = S_DONE;
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.busy      = !rst && (state != S_IDLE);
    assign bus.done      = !rst && (state == S_DONE);
    assign bus.state_dbg = state;

    vram_port_mux u_port_mux (
        .rst         (rst),
        .state       (state),
        .eng_r_en    (eng_r_en),
        .eng_r_addr  (eng_r_addr),
        .eng_w_en    (eng_w_en),
        .eng_w_addr  (eng_w_addr),
        .eng_w_data  (eng_w_data),
        .disp_r_en   (bus.disp_r_en),
        .disp_r_addr (bus.disp_r_addr),
        .cpu_w_valid (bus.cpu_w_valid),
        .cpu_w_addr  (bus.cpu_w_addr),
        .cpu_w_data  (bus.cpu_w_data),
        .cpu_w_ready (bus.cpu_w_ready),
        .ram_r_en    (bus.ram_r_en),
        .ram_r_addr  (bus.ram_r_addr),
        .ram_w_en    (bus.ram_w_en),
        .ram_w_addr  (bus.ram_w_addr),
        .ram_w_data  (bus.ram_w_data)
    );
endmodule
